// File: rtl/fault_sim_pkg.sv
// Shared types and constants for the fault-simulation response stage.
// The optional signature compactor is enabled by defining SYNDROME_MISR_EN.
package fault_sim_pkg;

    localparam int OUT_W_DEF    = 32;
    localparam int TEST_CNT_DEF = 51;
    localparam int FAULT_W_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_EMIT    = 2'd2
    } state_e;

    // Galois feedback taps (x^W term implied) for common signature widths.
    function automatic logic [63:0] misr_poly(input int unsigned w);
        logic [63:0] p;
        case (w)
            8:       p = 64'h0000_0000_0000_001D;
            16:      p = 64'h0000_0000_0000_1021;
            32:      p = 64'h0000_0000_04C1_1DB7;
            default: p = 64'h0000_0000_0000_001B;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/misr_compactor.sv
// Galois multiple-input signature register. clear loads the all-ones seed
// and has priority over enable.
module misr_compactor #(
    parameter int               W    = 32,
    parameter logic [W-1:0]     POLY = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] data,
    output logic [W-1:0] signature
);

    logic [W-1:0] sig_q;
    logic [W-1:0] sig_d;

    // Next signature: seed on clear, otherwise shift with feedback and fold data.
    always_comb begin
        sig_d = sig_q;
        if (clear) begin
            sig_d = '1;
        end else if (enable) begin
            sig_d = {sig_q[W-2:0], 1'b0} ^ (sig_q[W-1] ? POLY : '0) ^ data;
        end
    end

    // Signature register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign signature = sig_q;

endmodule

// File: rtl/fault_syndrome_collector.sv
// Per-fault syndrome builder: compares golden/faulty response pairs, one bit
// per test pattern, and emits one record per fault with running statistics.
// Define SYNDROME_MISR_EN to add a faulty-response signature to each record.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | waiting for fault_start; no pairs accepted
// ST_COLLECT | accepting one pair per cycle until pat_last
// ST_EMIT    | record held on rec_* until rec_ready
module fault_syndrome_collector
    import fault_sim_pkg::*;
#(
    parameter int OUT_W    = OUT_W_DEF,
    parameter int TEST_CNT = TEST_CNT_DEF,
    parameter int FAULT_W  = FAULT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fault_start,
    input  logic                pat_valid,
    output logic                pat_ready,
    input  logic                pat_last,
    input  logic [OUT_W-1:0]    golden,
    input  logic [OUT_W-1:0]    faulty,
    output logic                rec_valid,
    input  logic                rec_ready,
    output logic [FAULT_W-1:0]  rec_fault_idx,
    output logic [TEST_CNT-1:0] rec_syndrome,
    output logic                rec_detected,
    output logic                rec_overflow,
    output logic [OUT_W-1:0]    rec_signature,
    output logic [FAULT_W-1:0]  faults_total,
    output logic [FAULT_W-1:0]  faults_detected,
    output logic                busy
);

    // Index saturates at TEST_CNT, so it needs one value beyond the last bit.
    localparam int IDX_W = $clog2(TEST_CNT + 1);

    state_e              state_q, state_d;
    logic [TEST_CNT-1:0] syndrome_q, syndrome_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                overflow_q, overflow_d;
    logic [FAULT_W-1:0]  fault_idx_q, fault_idx_d;
    logic [FAULT_W-1:0]  total_q, total_d;
    logic [FAULT_W-1:0]  detected_q, detected_d;

    logic sess_clear;
    logic pat_fire;
    logic rec_fire;
    logic mismatch;

    assign mismatch = (golden != faulty);
    assign pat_fire = pat_valid && pat_ready;
    assign rec_fire = rec_valid && rec_ready;

    // FSM next-state and handshake outputs.
    always_comb begin
        state_d    = state_q;
        pat_ready  = 1'b0;
        rec_valid  = 1'b0;
        sess_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fault_start) begin
                    sess_clear = 1'b1;
                    state_d    = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                pat_ready = 1'b1;
                if (pat_valid && pat_last) begin
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                rec_valid = 1'b1;
                if (rec_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Session datapath: syndrome bits, pattern index and overflow flag.
    always_comb begin
        syndrome_d = syndrome_q;
        idx_d      = idx_q;
        overflow_d = overflow_q;
        if (sess_clear) begin
            syndrome_d = '0;
            idx_d      = '0;
            overflow_d = 1'b0;
        end else if (pat_fire) begin
            if (idx_q < IDX_W'(TEST_CNT)) begin
                for (int i = 0; i < TEST_CNT; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        syndrome_d[i] = mismatch;
                    end
                end
                idx_d = idx_q + 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    // Statistics and record ordinal, all saturating, advanced on record handshake.
    always_comb begin
        fault_idx_d = fault_idx_q;
        total_d     = total_q;
        detected_d  = detected_q;
        if (rec_fire) begin
            if (fault_idx_q != '1) begin
                fault_idx_d = fault_idx_q + 1'b1;
            end
            if (total_q != '1) begin
                total_d = total_q + 1'b1;
            end
            if (rec_detected && (detected_q != '1)) begin
                detected_d = detected_q + 1'b1;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            syndrome_q  <= '0;
            idx_q       <= '0;
            overflow_q  <= 1'b0;
            fault_idx_q <= '0;
            total_q     <= '0;
            detected_q  <= '0;
        end else begin
            state_q     <= state_d;
            syndrome_q  <= syndrome_d;
            idx_q       <= idx_d;
            overflow_q  <= overflow_d;
            fault_idx_q <= fault_idx_d;
            total_q     <= total_d;
            detected_q  <= detected_d;
        end
    end

    assign rec_syndrome    = syndrome_q;
    assign rec_detected    = |syndrome_q;
    assign rec_overflow    = overflow_q;
    assign rec_fault_idx   = fault_idx_q;
    assign faults_total    = total_q;
    assign faults_detected = detected_q;
    assign busy            = (state_q != ST_IDLE);

`ifdef SYNDROME_MISR_EN
    localparam logic [63:0]      POLY_FULL = misr_poly(OUT_W);
    localparam logic [OUT_W-1:0] POLY      = POLY_FULL[OUT_W-1:0];

    // Overflow pairs are folded too, so the signature covers the whole stream.
    misr_compactor #(
        .W    (OUT_W),
        .POLY (POLY)
    ) u_misr (
        .clk       (clk),
        .rst       (rst),
        .clear     (sess_clear),
        .enable    (pat_fire),
        .data      (faulty),
        .signature (rec_signature)
    );
`else
    assign rec_signature = '0;
`endif

endmodule

// File: tb/tb_fault_syndrome_collector.sv
// Directed bench for fault_syndrome_collector (default build and SYNDROME_MISR_EN).
module tb_fault_syndrome_collector;

    localparam int OUT_W    = 32;
    localparam int TEST_CNT = 51;
    localparam int FAULT_W  = 16;
    localparam logic [31:0] POLY = 32'h04C1_1DB7;

    logic                clk = 1'b0;
    logic                rst;
    logic                fault_start;
    logic                pat_valid;
    logic                pat_ready;
    logic                pat_last;
    logic [OUT_W-1:0]    golden;
    logic [OUT_W-1:0]    faulty;
    logic                rec_valid;
    logic                rec_ready;
    logic [FAULT_W-1:0]  rec_fault_idx;
    logic [TEST_CNT-1:0] rec_syndrome;
    logic                rec_detected;
    logic                rec_overflow;
    logic [OUT_W-1:0]    rec_signature;
    logic [FAULT_W-1:0]  faults_total;
    logic [FAULT_W-1:0]  faults_detected;
    logic                busy;

    int checks = 0;
    int errors = 0;
    int exp_total = 0;
    int exp_det = 0;
    logic [31:0] exp_sig;

    always #5 clk = ~clk;

    fault_syndrome_collector #(
        .OUT_W(OUT_W), .TEST_CNT(TEST_CNT), .FAULT_W(FAULT_W)
    ) dut (
        .clk(clk), .rst(rst), .fault_start(fault_start),
        .pat_valid(pat_valid), .pat_ready(pat_ready), .pat_last(pat_last),
        .golden(golden), .faulty(faulty),
        .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_fault_idx(rec_fault_idx), .rec_syndrome(rec_syndrome),
        .rec_detected(rec_detected), .rec_overflow(rec_overflow),
        .rec_signature(rec_signature),
        .faults_total(faults_total), .faults_detected(faults_detected),
        .busy(busy)
    );

    // Drive and sample 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Open a session and stream n pairs; pair i mismatches in bit 0 when
    // mm[i] is set, and in bit 31 when i == flip. Ends in EMIT.
    task automatic collect(input int n, input logic [63:0] mm, input int flip,
                           input logic [31:0] gbase);
        logic [31:0] f;
        fault_start = 1'b1;
        tick();
        fault_start = 1'b0;
        checks++;
        if (pat_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_ready got %b want 1", pat_ready);
        end
        exp_sig = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            f = gbase ^ (mm[i] ? 32'h1 : 32'h0) ^ ((i == flip) ? 32'h8000_0000 : 32'h0);
            pat_valid = 1'b1;
            golden    = gbase;
            faulty    = f;
            pat_last  = (i == n - 1);
            exp_sig   = {exp_sig[30:0], 1'b0} ^ (exp_sig[31] ? POLY : 32'h0) ^ f;
            tick();
        end
        pat_valid = 1'b0;
        pat_last  = 1'b0;
        checks++;
        if (rec_valid !== 1'b1 || pat_ready !== 1'b0) begin
            errors++;
            $display("FAIL emit_entry got valid=%b ready=%b want 1 0", rec_valid, pat_ready);
        end
    endtask

    // Complete the record handshake and check the statistics that follow it.
    task automatic handshake(input logic det);
        rec_ready = 1'b1;
        tick();
        rec_ready = 1'b0;
        exp_total++;
        if (det) exp_det++;
        checks++;
        if (faults_total !== FAULT_W'(exp_total) || faults_detected !== FAULT_W'(exp_det)
            || busy !== 1'b0) begin
            errors++;
            $display("FAIL stats got total=%0d det=%0d busy=%b want %0d %0d 0",
                     faults_total, faults_detected, busy, exp_total, exp_det);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; fault_start = 0; pat_valid = 0; pat_last = 0;
        golden = '0; faulty = '0; rec_ready = 0;
        repeat (3) tick();
        checks++;
        if (pat_ready !== 0 || rec_valid !== 0 || busy !== 0) begin
            errors++;
            $display("FAIL reset_ctrl got ready=%b valid=%b busy=%b want 0 0 0",
                     pat_ready, rec_valid, busy);
        end
        checks++;
        if (rec_syndrome !== '0 || rec_detected !== 0 || rec_overflow !== 0
            || rec_signature !== '0) begin
            errors++;
            $display("FAIL reset_rec got syn=%h det=%b ovf=%b sig=%h want 0",
                     rec_syndrome, rec_detected, rec_overflow, rec_signature);
        end
        checks++;
        if (rec_fault_idx !== '0 || faults_total !== '0 || faults_detected !== '0) begin
            errors++;
            $display("FAIL reset_stats got idx=%0d tot=%0d det=%0d want 0",
                     rec_fault_idx, faults_total, faults_detected);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_no_detect();
        collect(51, 64'h0, -1, 32'h0000_1234);
        checks++;
        if (rec_syndrome !== 51'h0 || rec_detected !== 0 || rec_overflow !== 0
            || rec_fault_idx !== 16'd0) begin
            errors++;
            $display("FAIL no_detect got syn=%h det=%b ovf=%b idx=%0d want 0 0 0 0",
                     rec_syndrome, rec_detected, rec_overflow, rec_fault_idx);
        end
        handshake(1'b0);
    endtask

    task automatic test_detect_ends();
        collect(51, 64'h0004_0000_0000_0001, -1, 32'h0000_1234);
        checks++;
        if (rec_syndrome !== 51'h4_0000_0000_0001 || rec_detected !== 1
            || rec_overflow !== 0 || rec_fault_idx !== 16'd1) begin
            errors++;
            $display("FAIL detect_ends got syn=%h det=%b ovf=%b idx=%0d want 4000000000001 1 0 1",
                     rec_syndrome, rec_detected, rec_overflow, rec_fault_idx);
        end
        handshake(1'b1);
    endtask

    task automatic test_overflow();
        collect(53, 64'h0010_0000_0000_0000, -1, 32'h5A5A_0F0F);
        checks++;
        if (rec_syndrome !== 51'h0 || rec_overflow !== 1 || rec_detected !== 0) begin
            errors++;
            $display("FAIL overflow got syn=%h ovf=%b det=%b want 0 1 0",
                     rec_syndrome, rec_overflow, rec_detected);
        end
        handshake(1'b0);
    endtask

    task automatic test_backpressure();
        collect(3, 64'h4, -1, 32'h0000_00FF);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (rec_valid !== 1 || rec_syndrome !== 51'h4 || rec_detected !== 1
                || rec_fault_idx !== 16'd3 || faults_total !== FAULT_W'(exp_total)
                || faults_detected !== FAULT_W'(exp_det)) begin
                errors++;
                $display("FAIL hold_%0d got v=%b syn=%h idx=%0d tot=%0d want 1 4 3 %0d",
                         c, rec_valid, rec_syndrome, rec_fault_idx, faults_total, exp_total);
            end
            tick();
        end
        handshake(1'b1);
        checks++;
        if (rec_fault_idx !== 16'd4) begin
            errors++;
            $display("FAIL next_idx got %0d want 4", rec_fault_idx);
        end
    endtask

    task automatic test_fault_start_ignored();
        fault_start = 1'b1;
        tick();
        fault_start = 1'b0;
        golden = 32'h1111_2222;
        faulty = 32'h1111_2222;
        pat_valid = 1'b1;
        repeat (2) tick();
        pat_valid = 1'b0;
        fault_start = 1'b1;
        tick();
        fault_start = 1'b0;
        checks++;
        if (pat_ready !== 1'b1) begin
            errors++;
            $display("FAIL restart_state got ready=%b want 1", pat_ready);
        end
        faulty = 32'h1111_2223;
        pat_valid = 1'b1;
        pat_last  = 1'b1;
        tick();
        pat_valid = 1'b0;
        pat_last  = 1'b0;
        checks++;
        if (rec_valid !== 1 || rec_syndrome !== 51'h4) begin
            errors++;
            $display("FAIL restart_ignored got v=%b syn=%h want 1 4", rec_valid, rec_syndrome);
        end
        handshake(1'b1);
    endtask

    task automatic test_idle_pairs();
        pat_valid = 1'b1;
        pat_last  = 1'b1;
        golden = 32'h0;
        faulty = 32'h1;
        repeat (2) begin
            tick();
            checks++;
            if (pat_ready !== 0 || rec_valid !== 0 || busy !== 0) begin
                errors++;
                $display("FAIL idle_pair got ready=%b valid=%b busy=%b want 0 0 0",
                         pat_ready, rec_valid, busy);
            end
        end
        pat_valid = 1'b0;
        pat_last  = 1'b0;
    endtask

    task automatic test_back_to_back();
        collect(2, 64'h0, -1, 32'hDEAD_BEEF);
        handshake(1'b0);
        collect(2, 64'h2, -1, 32'hDEAD_BEEF);
        checks++;
        if (rec_syndrome !== 51'h2 || rec_fault_idx !== FAULT_W'(exp_total)) begin
            errors++;
            $display("FAIL b2b_rec got syn=%h idx=%0d want 2 %0d",
                     rec_syndrome, rec_fault_idx, exp_total);
        end
        handshake(1'b1);
    endtask

    task automatic test_misr();
`ifdef SYNDROME_MISR_EN
        logic [31:0] sig1;
        collect(4, 64'h0, -1, 32'hCAFE_0001);
        sig1 = rec_signature;
        checks++;
        if (rec_signature !== exp_sig) begin
            errors++;
            $display("FAIL misr_a got %h want %h", rec_signature, exp_sig);
        end
        handshake(1'b0);
        collect(4, 64'h0, -1, 32'hCAFE_0001);
        checks++;
        if (rec_signature !== sig1) begin
            errors++;
            $display("FAIL misr_repeat got %h want %h", rec_signature, sig1);
        end
        handshake(1'b0);
        collect(4, 64'h0, 2, 32'hCAFE_0001);
        checks++;
        if (rec_signature === sig1 || rec_signature !== exp_sig) begin
            errors++;
            $display("FAIL misr_flip got %h want %h (not %h)", rec_signature, exp_sig, sig1);
        end
        handshake(1'b1);
`else
        collect(4, 64'h0, 2, 32'hCAFE_0001);
        checks++;
        if (rec_signature !== 32'h0) begin
            errors++;
            $display("FAIL misr_off got %h want 0", rec_signature);
        end
        handshake(1'b1);
`endif
    endtask

    task automatic test_rst_in_emit();
        collect(2, 64'h1, -1, 32'h0F0F_0F0F);
        rst = 1'b1;
        tick();
        checks++;
        if (rec_valid !== 0 || faults_total !== '0 || faults_detected !== '0
            || rec_fault_idx !== '0 || busy !== 0 || rec_syndrome !== '0) begin
            errors++;
            $display("FAIL rst_emit got v=%b tot=%0d det=%0d idx=%0d busy=%b syn=%h want all 0",
                     rec_valid, faults_total, faults_detected, rec_fault_idx, busy, rec_syndrome);
        end
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_no_detect();
        test_detect_ends();
        test_overflow();
        test_backpressure();
        test_fault_start_ignored();
        test_idle_pairs();
        test_back_to_back();
        test_misr();
        test_rst_in_emit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
